// File: rtl/exu_trap_cmt_if.sv
// Trap commit bundle: commit request, CSR access and IFU redirect.
// master drives commit/CSR/ack, slave is the trap commit stage.
interface exu_trap_cmt_if #(
  parameter int XLEN = 32
);
  logic            cmt_trap_valid;
  logic [XLEN-1:0] cmt_cause;
  logic [XLEN-1:0] cmt_pc;
  logic            cmt_mret_valid;
  logic            cmt_ready;
  logic            csr_wr_ena;
  logic [11:0]     csr_wr_addr;
  logic [XLEN-1:0] csr_wr_data;
  logic [11:0]     csr_rd_addr;
  logic [XLEN-1:0] csr_rd_data;
  logic            flush_req;
  logic [XLEN-1:0] flush_pc;
  logic            flush_ack;

  modport master (
    output cmt_trap_valid, cmt_cause, cmt_pc,
    output cmt_mret_valid,
    output csr_wr_ena, csr_wr_addr, csr_wr_data,
    output csr_rd_addr, flush_ack,
    input  cmt_ready, csr_rd_data,
    input  flush_req, flush_pc
  );

  modport slave (
    input  cmt_trap_valid, cmt_cause, cmt_pc,
    input  cmt_mret_valid,
    input  csr_wr_ena, csr_wr_addr, csr_wr_data,
    input  csr_rd_addr, flush_ack,
    output cmt_ready, csr_rd_data,
    output flush_req, flush_pc
  );
endinterface

// File: rtl/exu_trap_cmt.sv
// Trap commit stage: M-mode trap CSRs and a held IFU
// redirect that stalls commit until acknowledged.
module exu_trap_cmt #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800
) (
  input logic             clk,
  input logic             rst,
  exu_trap_cmt_if.slave   bus
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [XLEN-1:0] r_mstatus;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_flush_pc;
  logic [XLEN-1:0] w_mst_trap;
  logic [XLEN-1:0] w_mst_mret;
  logic            w_ready;
  logic            w_trap;
  logic            w_mret;

  assign w_trap = bus.cmt_trap_valid & w_ready;
  assign w_mret = bus.cmt_mret_valid & w_ready
                & ~bus.cmt_trap_valid;

  // Full next mstatus images so a same-cycle CSR write is overridden
  always_comb begin
    w_mst_trap        = r_mstatus;
    w_mst_trap[7]     = r_mstatus[3];
    w_mst_trap[3]     = 1'b0;
    w_mst_trap[12:11] = 2'b11;
    w_mst_mret        = r_mstatus;
    w_mst_mret[3]     = r_mstatus[7];
    w_mst_mret[7]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (w_trap | w_mret) w_state_nx = S_FLUSH;
      S_FLUSH: if (bus.flush_ack)   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready       = (r_state == S_IDLE);
    bus.cmt_ready = w_ready;
    bus.flush_req = (r_state == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mstatus  <= MSTATUS_RST;
      r_mtvec    <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_flush_pc <= '0;
    end else begin
      if (bus.csr_wr_ena) begin
        unique case (bus.csr_wr_addr)
          A_MSTATUS: r_mstatus <= bus.csr_wr_data;
          A_MTVEC:   r_mtvec   <= bus.csr_wr_data;
          A_MEPC:    r_mepc    <= bus.csr_wr_data;
          A_MCAUSE:  r_mcause  <= bus.csr_wr_data;
          default:   ;
        endcase
      end
      if (w_trap) begin
        r_mepc     <= bus.cmt_pc;
        r_mcause   <= bus.cmt_cause;
        r_mstatus  <= w_mst_trap;
        r_flush_pc <= {r_mtvec[XLEN-1:2], 2'b00};
      end else if (w_mret) begin
        r_mstatus  <= w_mst_mret;
        r_flush_pc <= r_mepc;
      end
    end
  end

  assign bus.flush_pc = r_flush_pc;

  always_comb begin
    bus.csr_rd_data = '0;
    unique case (1'b1)
      (bus.csr_rd_addr == A_MSTATUS): bus.csr_rd_data = r_mstatus;
      (bus.csr_rd_addr == A_MTVEC):   bus.csr_rd_data = r_mtvec;
      (bus.csr_rd_addr == A_MEPC):    bus.csr_rd_data = r_mepc;
      (bus.csr_rd_addr == A_MCAUSE):  bus.csr_rd_data = r_mcause;
      default:                        bus.csr_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_exu_trap_cmt.sv
// Directed per-cycle vector bench for exu_trap_cmt.
// Each row: inputs for one cycle and outputs expected in it.
module tb_exu_trap_cmt;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  exu_trap_cmt_if #(.XLEN(32)) bus ();

  exu_trap_cmt #(
    .XLEN(32),
    .MSTATUS_RST(32'h0000_1800)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        tv;
    logic        mv;
    logic [31:0] cause;
    logic [31:0] pc;
    logic        we;
    logic [11:0] wa;
    logic [31:0] wd;
    logic        ack;
    logic [11:0] ra;
    logic        rdy;
    logic        req;
    logic        cfp;
    logic [31:0] fpc;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    input logic rs, input logic tv, input logic mv,
    input logic [31:0] cs, input logic [31:0] pc,
    input logic we, input logic [11:0] wa,
    input logic [31:0] wd, input logic ack,
    input logic [11:0] ra, input logic rdy,
    input logic req, input logic cfp,
    input logic [31:0] fpc, input logic [31:0] rd);
    vec_t t;
    t.rst = rs; t.tv = tv; t.mv = mv;
    t.cause = cs; t.pc = pc;
    t.we = we; t.wa = wa; t.wd = wd;
    t.ack = ack; t.ra = ra;
    t.rdy = rdy; t.req = req; t.cfp = cfp;
    t.fpc = fpc; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst                = t.rst;
    bus.cmt_trap_valid = t.tv;
    bus.cmt_mret_valid = t.mv;
    bus.cmt_cause      = t.cause;
    bus.cmt_pc         = t.pc;
    bus.csr_wr_ena     = t.we;
    bus.csr_wr_addr    = t.wa;
    bus.csr_wr_data    = t.wd;
    bus.flush_ack      = t.ack;
    bus.csr_rd_addr    = t.ra;
  endtask

  task automatic idle_in();
    drive(v(0,0,0,0,0,0,0,0,0,12'h300,0,0,0,0,0));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(v(1,0,0,0,0,0,0,0,0,12'h300,0,0,0,0,0));
    @(posedge clk);
    @(posedge clk);

    // rs tv mv cause pc we wa wd ack ra | rdy req cfp fpc rd
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h300,
                    1,0,1,32'h0,32'h1800));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h341,
                    1,0,0,0,32'h0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h342,
                    1,0,0,0,32'h0));
    tbl.push_back(v(0,0,0,0,0,1,12'h305,32'h8000_0103,0,12'h305,
                    1,0,0,0,32'h0));
    tbl.push_back(v(0,0,0,0,0,1,12'h300,32'h1808,0,12'h305,
                    1,0,0,0,32'h8000_0103));
    tbl.push_back(v(0,1,0,3,32'h8000_0010,0,0,0,0,12'h300,
                    1,0,0,0,32'h1808));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h341,
                    0,1,1,32'h8000_0100,32'h8000_0010));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h342,
                    0,1,1,32'h8000_0100,32'h3));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,12'h300,
                    0,1,1,32'h8000_0100,32'h1880));
    // mret with immediate ack
    tbl.push_back(v(0,0,1,0,0,0,0,0,0,12'h300,
                    1,0,0,0,32'h1880));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,12'h300,
                    0,1,1,32'h8000_0010,32'h1888));
    // trap and mret together
    tbl.push_back(v(0,1,1,3,32'h8000_0020,0,0,0,0,12'h300,
                    1,0,0,0,32'h1888));
    // second trap held during FLUSH
    tbl.push_back(v(0,1,0,5,32'h8000_0030,0,0,0,0,12'h341,
                    0,1,1,32'h8000_0100,32'h8000_0020));
    tbl.push_back(v(0,1,0,5,32'h8000_0030,0,0,0,1,12'h342,
                    0,1,1,32'h8000_0100,32'h3));
    // accepted now, with colliding mepc write
    tbl.push_back(v(0,1,0,5,32'h8000_0030,1,12'h341,32'hDEAD_0000,0,
                    12'h300,1,0,0,0,32'h1880));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,12'h341,
                    0,1,1,32'h8000_0100,32'h8000_0030));
    // trap with same-cycle mtvec write
    tbl.push_back(v(0,1,0,7,32'h8000_0040,1,12'h305,32'h1000,0,
                    12'h342,1,0,0,0,32'h5));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,12'h305,
                    0,1,1,32'h8000_0100,32'h1000));
    tbl.push_back(v(0,1,0,2,32'h8000_0050,0,0,0,0,12'h342,
                    1,0,0,0,32'h7));
    tbl.push_back(v(0,0,0,0,0,1,12'h300,32'h0008,0,12'h341,
                    0,1,1,32'h1000,32'h8000_0050));
    // reset mid-FLUSH
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,12'h300,
                    0,1,1,32'h1000,32'h0008));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h300,
                    1,0,1,32'h0,32'h1800));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h341,
                    1,0,0,0,32'h0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,1,12'h305,
                    1,0,0,0,32'h0));
    tbl.push_back(v(0,0,0,0,0,1,12'h343,32'hFF,0,12'h342,
                    1,0,0,0,32'h0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,12'h343,
                    1,0,0,0,32'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("rdy[%0d]", i),
          {31'd0, bus.cmt_ready}, {31'd0, tbl[i].rdy});
      chk($sformatf("req[%0d]", i),
          {31'd0, bus.flush_req}, {31'd0, tbl[i].req});
      if (tbl[i].cfp)
        chk($sformatf("fpc[%0d]", i), bus.flush_pc, tbl[i].fpc);
      chk($sformatf("rd[%0d]", i), bus.csr_rd_data, tbl[i].rd);
    end

    // hand sequence: trap, bounded wait for redirect, held ack
    @(negedge clk);
    drive(v(0,1,0,32'hB,32'h100,1,12'h305,32'h2003,0,12'h341,
            0,0,0,0,0));
    @(negedge clk);
    idle_in();
    begin
      int n;
      n = 0;
      while (!bus.flush_req && n < 4) begin
        @(negedge clk);
        n++;
      end
      #1;
      chk("hs_req_wait", {31'd0, bus.flush_req}, 32'd1);
      chk("hs_lat", n, 0);
    end
    chk("hs_fpc0", bus.flush_pc, 32'h0);
    chk("hs_rdy0", {31'd0, bus.cmt_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("hs_fpc1", bus.flush_pc, 32'h0);
    bus.flush_ack = 1'b1;
    @(negedge clk);
    bus.flush_ack = 1'b0;
    bus.csr_rd_addr = 12'h342;
    #1;
    chk("hs_rdy1", {31'd0, bus.cmt_ready}, 32'd1);
    chk("hs_req1", {31'd0, bus.flush_req}, 32'd0);
    chk("hs_cause", bus.csr_rd_data, 32'hB);

    // next trap uses the mtvec written alongside the last one
    bus.cmt_trap_valid = 1'b1;
    bus.cmt_pc = 32'h200;
    @(negedge clk);
    bus.cmt_trap_valid = 1'b0;
    #1;
    chk("hs_fpc2", bus.flush_pc, 32'h2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want done");
    $fatal(1);
  end

endmodule
